// File: rtl/dm_pkg.sv
// Shared constants, requester-select encoding and access-fault check for the
// data-memory access arbiter.
package dm_pkg;

  localparam int unsigned DM_DEPTH = 24;
  localparam int unsigned DM_IDX_W = 5;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_CPU  = 2'b01,
    SEL_LD   = 2'b10
  } sel_e;

  // A fault is a misaligned byte address or a word index past the array end.
  function automatic logic dm_fault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dm_access_arbiter_starve_ctr.sv
// Loader starvation guard: counts consecutive denied loader cycles and
// raises force_ld once the count saturates at LIMIT.
module dm_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic force_ld
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!ld_req || ld_gnt) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_ld = (cnt_q == LIM);

endmodule

// File: rtl/dm_access_arbiter.sv
// Single-port data-memory controller shared by the MEM stage and the loader:
// fixed CPU priority with a loader starvation guard, fault checks, 1-cycle reads.
module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH        = DM_DEPTH,
  parameter int unsigned IDX_W        = DM_IDX_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_wdata,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  output logic [31:0]      ld_rdata,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             err,
  output logic [31:0]      err_addr
);

  sel_e        sel;
  logic        force_ld;
  logic        g_we, g_fault;
  logic [31:0] g_addr, g_wdata, rd_word;

  logic        cpu_rvalid_q, cpu_rvalid_d, ld_rvalid_q, ld_rvalid_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  dm_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .ld_req   (ld_req),
    .ld_gnt   (ld_gnt),
    .force_ld (force_ld)
  );

  // Nothing is granted while reset is held, so no access slips through it.
  always_comb begin
    sel = SEL_NONE;
    if (!rst) begin
      if (cpu_req && ld_req) begin
        sel = force_ld ? SEL_LD : SEL_CPU;
      end else if (cpu_req) begin
        sel = SEL_CPU;
      end else if (ld_req) begin
        sel = SEL_LD;
      end
    end
  end

  assign cpu_gnt   = (sel == SEL_CPU);
  assign ld_gnt    = (sel == SEL_LD);
  assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

  always_comb begin
    g_addr  = 32'h0;
    g_wdata = 32'h0;
    g_we    = 1'b0;
    unique case (sel)
      SEL_CPU: begin
        g_addr  = cpu_addr;
        g_wdata = cpu_wdata;
        g_we    = cpu_we;
      end
      SEL_LD: begin
        g_addr  = ld_addr;
        g_wdata = ld_wdata;
        g_we    = ld_we;
      end
      default: ;
    endcase
    g_fault = (sel != SEL_NONE) && dm_fault(g_addr, DEPTH);
    rd_word = g_fault ? 32'h0 : mem_rdata;
  end

  assign mem_we    = (sel != SEL_NONE) & g_we & ~g_fault;
  assign mem_idx   = g_addr[IDX_W+1:2];
  assign mem_wdata = g_wdata;

  // Load data is captured at the grant edge; rdata holds between loads.
  always_comb begin
    cpu_rvalid_d = (sel == SEL_CPU) && !g_we;
    ld_rvalid_d  = (sel == SEL_LD) && !g_we;
    cpu_rdata_d  = cpu_rvalid_d ? rd_word : cpu_rdata_q;
    ld_rdata_d   = ld_rvalid_d ? rd_word : ld_rdata_q;
    err_d        = err_q | g_fault;
    err_addr_d   = (g_fault && !err_q) ? g_addr : err_addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rdata_q  <= 32'h0;
      ld_rdata_q   <= 32'h0;
      err_q        <= 1'b0;
      err_addr_q   <= 32'h0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      ld_rvalid_q  <= ld_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ld_rvalid  = ld_rvalid_q;
  assign ld_rdata   = ld_rdata_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Scoreboard bench for dm_access_arbiter: a word-array reference model predicts
// grants, memory strobes, errors and queued read returns.
module tb_dm_access_arbiter;

  localparam int DEPTH = 24;
  localparam int LIMIT = 4;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = 32'h0, ld_wdata = 32'h0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid;
  logic [31:0] cpu_rdata, ld_rdata;
  logic        mem_we;
  logic [4:0]  mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
  logic        err;
  logic [31:0] err_addr;

  logic [31:0] phys [0:31];
  logic [31:0] gold [0:DEPTH-1];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   mon_en = 1'b0;
  bit   mon_e;
  int   ld_wait = 0;
  bit   exp_err = 1'b0;
  logic [31:0] exp_err_addr = 32'h0;
  logic [31:0] last_cpu = 32'h0, last_ld = 32'h0;
  bit   mdl_cpu_gnt, mdl_ld_gnt, obs_cpu_gnt, obs_ld_gnt;
  exp_t exp_cpu[$];
  exp_t exp_ld[$];

  always #5 clk = ~clk;

  dm_access_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .ld_rvalid  (ld_rvalid),
    .ld_rdata   (ld_rdata),
    .mem_we     (mem_we),
    .mem_idx    (mem_idx),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .err        (err),
    .err_addr   (err_addr)
  );

  // Physical word array the DUT drives; the reference lives in gold[].
  assign mem_rdata = phys[mem_idx];
  always @(posedge clk) begin
    if (mem_we) phys[mem_idx] <= mem_wdata;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t mk(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_t t;
    t.req = r; t.we = w; t.addr = a; t.wd = d;
    return t;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input bit r, input req_t c, input req_t l);
    @(posedge clk);
    #1;
    rst = r;
    cpu_req = c.req; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wd;
    ld_req  = l.req; ld_we  = l.we; ld_addr  = l.addr; ld_wdata  = l.wd;
  endtask

  // At the falling edge: predict this cycle's grant and issue, compare, update model.
  task automatic checkOutput();
    bit g_cpu, g_ld, flt, w;
    logic [31:0] a, d, rdv;
    exp_t e;
    @(negedge clk);
    g_cpu = 1'b0;
    g_ld  = 1'b0;
    if (rst) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_idx", mem_idx, 0);
      if (rst_q) begin
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ld_rvalid", ld_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
      end
      ld_wait = 0;
      exp_err = 1'b0;
      exp_err_addr = 32'h0;
    end else begin
      chk("err", err, exp_err);
      chk("err_addr", err_addr, exp_err_addr);
      if (cpu_req && ld_req) begin
        if (ld_wait >= LIMIT) g_ld = 1'b1;
        else g_cpu = 1'b1;
      end else if (cpu_req) begin
        g_cpu = 1'b1;
      end else if (ld_req) begin
        g_ld = 1'b1;
      end
      chk("cpu_gnt", cpu_gnt, g_cpu);
      chk("ld_gnt", ld_gnt, g_ld);
      chk("cpu_stall", cpu_stall, cpu_req && !g_cpu);
      ld_wait = (ld_req && !g_ld) ? ld_wait + 1 : 0;
      if (g_cpu || g_ld) begin
        a   = g_cpu ? cpu_addr : ld_addr;
        d   = g_cpu ? cpu_wdata : ld_wdata;
        w   = g_cpu ? cpu_we : ld_we;
        flt = is_fault(a);
        chk("mem_idx", mem_idx, (a >> 2) & 32'd31);
        chk("mem_we", mem_we, w && !flt);
        if (w && !flt) begin
          chk("mem_wdata", mem_wdata, d);
          gold[a / 4] = d;
        end
        if (!w) begin
          rdv    = flt ? 32'h0 : gold[a / 4];
          e.cyc  = cyc + 1;
          e.data = rdv;
          if (g_cpu) exp_cpu.push_back(e);
          else exp_ld.push_back(e);
        end
        if (flt) begin
          if (!exp_err) exp_err_addr = a;
          exp_err = 1'b1;
        end
      end else begin
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_idx", mem_idx, 0);
      end
    end
    mdl_cpu_gnt = g_cpu;
    mdl_ld_gnt  = g_ld;
    obs_cpu_gnt = cpu_gnt;
    obs_ld_gnt  = ld_gnt;
  endtask

  task automatic step(input bit r, input req_t c, input req_t l);
    applyStimulus(r, c, l);
    checkOutput();
  endtask

  // Read-return monitor: pops an expectation exactly in the cycle it is due.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        while (exp_cpu.size() > 0 && exp_cpu[0].cyc <= cyc) void'(exp_cpu.pop_front());
        while (exp_ld.size() > 0 && exp_ld[0].cyc <= cyc) void'(exp_ld.pop_front());
        last_cpu = 32'h0;
        last_ld  = 32'h0;
      end else begin
        mon_e = (exp_cpu.size() > 0) && (exp_cpu[0].cyc == cyc);
        if (mon_e) begin
          chk("cpu_rvalid", cpu_rvalid, 1);
          chk("cpu_rdata", cpu_rdata, exp_cpu[0].data);
          last_cpu = exp_cpu[0].data;
          void'(exp_cpu.pop_front());
        end else begin
          chk("cpu_rvalid_idle", cpu_rvalid, 0);
          chk("cpu_rdata_hold", cpu_rdata, last_cpu);
        end
        mon_e = (exp_ld.size() > 0) && (exp_ld[0].cyc == cyc);
        if (mon_e) begin
          chk("ld_rvalid", ld_rvalid, 1);
          chk("ld_rdata", ld_rdata, exp_ld[0].data);
          last_ld = exp_ld[0].data;
          void'(exp_ld.pop_front());
        end else begin
          chk("ld_rvalid_idle", ld_rvalid, 0);
          chk("ld_rdata_hold", ld_rdata, last_ld);
        end
      end
    end
  end

  function automatic logic [31:0] gen_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'($urandom_range(DEPTH, 31) * 4);
    if (r == 2) return 32'h200;
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  req_t idle, cp, lp;

  initial begin
    idle = mk(0, 0, 32'h0, 32'h0);
    $display("[TB] start");
    step(1, idle, idle);
    mon_en = 1'b1;
    step(1, idle, idle);
    step(0, idle, idle);

    // Loader preload of the whole array, one grant per cycle.
    for (int i = 0; i < DEPTH; i++) step(0, idle, mk(1, 1, 32'(i * 4), $urandom));

    // CPU store then load of the same word.
    step(0, mk(1, 1, 32'h8, 32'hDEADBEEF), idle);
    step(0, mk(1, 0, 32'h8, 32'h0), idle);
    step(0, idle, idle);
    chk("store_load_rdata", cpu_rdata, 32'hDEADBEEF);
    step(0, idle, idle);

    // Contention: loader forced ahead on the fifth contested cycle.
    for (int k = 0; k < 6; k++) begin
      step(0, mk(1, 0, 32'h10, 32'h0), mk(1, 0, 32'h14, 32'h0));
      chk("contend_cpu_gnt", obs_cpu_gnt, (k != 4));
      chk("contend_ld_gnt", obs_ld_gnt, (k == 4));
    end
    step(0, idle, idle);

    // Loader burst: writes then readback with no bubbles.
    step(0, idle, mk(1, 1, 32'h0, 32'h11111111));
    step(0, idle, mk(1, 1, 32'h4, 32'h22222222));
    step(0, idle, mk(1, 1, 32'h8, 32'h33333333));
    step(0, idle, mk(1, 0, 32'h0, 32'h0));
    step(0, idle, mk(1, 0, 32'h4, 32'h0));
    step(0, idle, mk(1, 0, 32'h8, 32'h0));
    step(0, idle, idle);
    chk("burst_last_rdata", ld_rdata, 32'h33333333);
    step(0, idle, idle);

    // Reset arriving right after a granted load drops its return.
    step(0, mk(1, 0, 32'h4, 32'h0), idle);
    rst = 1'b1;
    step(1, mk(1, 0, 32'h4, 32'h0), idle);
    step(0, mk(1, 0, 32'h4, 32'h0), idle);
    chk("regrant_after_rst", obs_cpu_gnt, 1);
    step(0, idle, idle);
    step(0, idle, idle);

    // Out-of-range loader load returns zero and flags an error.
    step(0, idle, mk(1, 0, 32'h60, 32'h0));
    step(0, idle, idle);
    chk("oor_err", err, 1);
    chk("oor_err_addr", err_addr, 32'h60);
    step(1, idle, idle);
    step(1, idle, idle);

    // Misaligned store, then a second fault that must not move err_addr.
    step(0, mk(1, 1, 32'h6, 32'hCAFEF00D), idle);
    step(0, idle, idle);
    chk("misalign_err_addr", err_addr, 32'h6);
    step(0, mk(1, 0, 32'h200, 32'h0), idle);
    step(0, idle, idle);
    chk("sticky_err_addr", err_addr, 32'h6);

    // Randomised traffic; each requester holds its request until granted.
    cp = idle;
    lp = idle;
    for (int n = 0; n < 800; n++) begin
      if (!cp.req && $urandom_range(0, 2) != 0) cp = mk(1, $urandom_range(0, 1), gen_addr(), $urandom);
      if (!lp.req && $urandom_range(0, 1) != 0) lp = mk(1, $urandom_range(0, 1), gen_addr(), $urandom);
      if ($urandom_range(0, 99) == 0) begin
        step(1, cp, lp);
      end else begin
        step(0, cp, lp);
        if (mdl_cpu_gnt) cp = idle;
        if (mdl_ld_gnt) lp = idle;
      end
    end
    step(0, idle, idle);
    step(0, idle, idle);
    step(0, idle, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
